muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the ALU in EX.
- EX issues an R-type op with funct7=0x01 via start_i. The pipeline stalls while busy_o is high.
- The result returns on done_o with the destination register address.
- Operand width is parametrised. An optional fast multiplier trades area for multiply latency.

---
 rtl/core_pkg.sv | 32 +++
 rtl/radix2_div_step.sv | 26 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: funct3 encodings and FSM states for the mul/div unit, plus writeback select.
// Pure type/constant package; no logic, latency or backpressure of its own.
package core_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_DONE
  } muldiv_state_e;

  // Mul/div results leave EX on the ALU writeback path.
  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

endpackage

// File: rtl/radix2_div_step.sv
// One restoring-division iteration on {rem, quo}: shift left, trial-subtract, keep if no borrow.
// Purely combinational, zero latency, no flow control.
module radix2_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = (shifted >= {1'b0, divisor});
    // rem < divisor on entry, so a successful subtract always fits back in XLEN bits.
    rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: XLEN-cycle shift-add multiply (or 2-cycle fast multiply), XLEN-cycle restoring divide.
// Divide special cases finish in 1 cycle; start_i is ignored while busy_o, so issue must hold and stall.
module muldiv_unit
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0,
  parameter int RADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o,
  output logic [RADDR_W-1:0] rd_addr_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q;
  logic               neg_q;
  logic [RADDR_W-1:0] rd_q;
  logic [XLEN-1:0]    a_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [CNT_W-1:0]   cnt_q;

  muldiv_op_e      op_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            accept, computing, last_iter;

  assign op_in = muldiv_op_e'(op_i);

  always_comb begin
    a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed & rs1_i[XLEN-1];
    b_neg    = b_signed & rs2_i[XLEN-1];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
    is_div   = op_i[2];
    div_zero = (rs2_i == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (rs1_i == INT_MIN) && (rs2_i == '1);
    special  = is_div && (div_zero || div_ovf);
    // op_i[1] separates REM* from DIV* within the divide group.
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else          special_res = op_i[1] ? '0 : INT_MIN;
  end

  assign accept    = start_i && !flush_i && (state_q == MD_IDLE || state_q == MD_DONE);
  assign computing = (state_q == MD_MUL || state_q == MD_DIV);
  assign last_iter = computing && (cnt_q == CNT_W'(1));

  // Datapath for one iteration.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [2*XLEN-1:0] acc_next;

  radix2_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc_q[2*XLEN-1:XLEN]),
    .quo      (acc_q[XLEN-1:0]),
    .divisor  (a_q),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    fast_prod = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    if (state_q == MD_DIV)  acc_next = {div_rem, div_quo};
    else if (FAST_MUL != 0) acc_next = fast_prod;
    else                    acc_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Sign fix-up is taken from the final iteration's output so it lands in the same edge.
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   mul_res, div_mag, div_res, final_res;

  always_comb begin
    mul_full  = neg_q ? -acc_next : acc_next;
    mul_res   = (op_q == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    div_mag   = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    div_res   = neg_q ? -div_mag : div_mag;
    final_res = op_q[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (accept) state_d = special ? MD_DONE : (is_div ? MD_DIV : MD_MUL);
      end
      MD_MUL, MD_DIV: begin
        busy_o = 1'b1;
        if (last_iter) state_d = MD_DONE;
      end
      MD_DONE: begin
        done_o  = 1'b1;
        state_d = MD_IDLE;
        if (accept) state_d = special ? MD_DONE : (is_div ? MD_DIV : MD_MUL);
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rd_q      <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      rd_q  <= rd_addr_i;
      neg_q <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
      a_q   <= is_div ? b_mag : a_mag;
      acc_q <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
      cnt_q <= ((FAST_MUL != 0) && !is_div) ? CNT_W'(1) : CNT_W'(XLEN);
      if (special) begin
        result_o  <= special_res;
        rd_addr_o <= rd_addr_i;
      end
    end else if (computing && !flush_i) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_iter) begin
        result_o  <= final_res;
        rd_addr_o <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush/reset/busy/back-to-back sequences.
module tb_muldiv_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0, start_f = 1'b0, flush_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        busy_o, done_o, busy_f, done_f;
  logic [31:0] result_o, result_f;
  logic [4:0]  rd_addr_o, rd_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FAST_MUL(0), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  muldiv_unit #(.XLEN(32), .FAST_MUL(1), .RADDR_W(5)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start_i(start_f), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_f), .done_o(done_f),
    .result_o(result_f), .rd_addr_o(rd_f)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
  endtask

  // Leaves the caller #1 after the accepting edge, i.e. at the sample point of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    drive(op, a, b, rd);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic busy_seen);
    lat = -1;
    busy_seen = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (busy_o) busy_seen = 1'b1;
      if (done_o) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done_fast(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (done_f) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   lat;
    logic bsy;
    int   ndone;
    logic [4:0]  seen_rd;
    logic [31:0] seen_res;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd3, 32'h80000000, 32'h00000002, 5'd4,  32'h00000001, 33};
    vecs[5]  = '{3'd4, 32'hFFFFFFEC, 32'h00000003, 5'd6,  32'hFFFFFFFA, 33};
    vecs[6]  = '{3'd6, 32'hFFFFFFEC, 32'h00000003, 5'd7,  32'hFFFFFFFE, 33};
    vecs[7]  = '{3'd5, 32'h00000014, 32'h00000003, 5'd8,  32'h00000006, 33};
    vecs[8]  = '{3'd7, 32'hFFFFFFFF, 32'h00000010, 5'd10, 32'h0000000F, 33};
    vecs[9]  = '{3'd4, 32'h00000005, 32'h00000000, 5'd11, 32'hFFFFFFFF, 1};
    vecs[10] = '{3'd7, 32'h00000005, 32'h00000000, 5'd12, 32'h00000005, 1};
    vecs[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1};
    vecs[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1};
    vecs[13] = '{3'd5, 32'h00000064, 32'h00000007, 5'd9,  32'h0000000E, 33};

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("reset busy_o", {31'd0, busy_o}, 32'd0);
    check("reset done_o", {31'd0, done_o}, 32'd0);
    check("reset result_o", result_o, 32'd0);
    check("reset rd_addr_o", {27'd0, rd_addr_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(lat, bsy);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d result", i), result_o, vecs[i].res);
      check($sformatf("vec%0d rd", i), {27'd0, rd_addr_o}, {27'd0, vecs[i].rd});
      if (vecs[i].lat == 1) check($sformatf("vec%0d busy never", i), {31'd0, bsy}, 32'd0);
    end

    // Fast multiplier.
    @(negedge clk);
    drive(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5);
    start_f = 1'b1;
    @(posedge clk);
    #1 start_f = 1'b0;
    wait_done_fast(lat);
    check("fast mul latency", lat, 2);
    check("fast mul result", result_f, 32'hFFFFFFEB);
    check("fast mul rd", {27'd0, rd_f}, 32'd5);
    @(negedge clk);
    drive(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17);
    start_f = 1'b1;
    @(posedge clk);
    #1 start_f = 1'b0;
    wait_done_fast(lat);
    check("fast mulhu latency", lat, 2);
    check("fast mulhu result", result_f, 32'hFFFFFFFE);

    // Flush at iteration 10; result_o keeps the last completed value (100/7 = 14, rd 9).
    issue(3'd4, 32'hFFFFFFEC, 32'h00000003, 5'd15);
    repeat (9) @(posedge clk);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush busy_o", {31'd0, busy_o}, 32'd0);
    check("flush done_o", {31'd0, done_o}, 32'd0);
    check("flush result held", result_o, 32'h0000000E);
    check("flush rd held", {27'd0, rd_addr_o}, 32'd9);
    issue(3'd5, 32'h00000014, 32'h00000003, 5'd16);
    wait_done(lat, bsy);
    check("post-flush latency", lat, 33);
    check("post-flush result", result_o, 32'h00000006);
    check("post-flush rd", {27'd0, rd_addr_o}, 32'd16);

    // Start together with flush is dropped.
    @(negedge clk);
    drive(3'd0, 32'h3, 32'h4, 5'd18);
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    check("start+flush busy_o", {31'd0, busy_o}, 32'd0);
    check("start+flush done_o", {31'd0, done_o}, 32'd0);

    // Start while busy is ignored.
    issue(3'd5, 32'h00000064, 32'h00000007, 5'd12);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive(3'd0, 32'h3, 32'h4, 5'd20);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    ndone = 0; seen_rd = '0; seen_res = '0;
    for (int n = 0; n < 80; n++) begin
      if (done_o) begin
        ndone++;
        if (ndone == 1) begin seen_rd = rd_addr_o; seen_res = result_o; end
      end
      @(posedge clk);
      #1;
    end
    check("busy-ignore done count", ndone, 1);
    check("busy-ignore rd", {27'd0, seen_rd}, 32'd12);
    check("busy-ignore result", seen_res, 32'h0000000E);

    // Reset mid-divide.
    issue(3'd4, 32'hFFFFFFEC, 32'h00000003, 5'd13);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst busy_o", {31'd0, busy_o}, 32'd0);
    check("midrst done_o", {31'd0, done_o}, 32'd0);
    check("midrst result_o", result_o, 32'd0);
    check("midrst rd_addr_o", {27'd0, rd_addr_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    issue(3'd7, 32'hFFFFFFFF, 32'h00000010, 5'd14);
    wait_done(lat, bsy);
    check("post-reset latency", lat, 33);
    check("post-reset result", result_o, 32'h0000000F);
    check("post-reset rd", {27'd0, rd_addr_o}, 32'd14);

    // Back-to-back: start held high through the DONE cycle.
    @(negedge clk);
    drive(3'd5, 32'h00000014, 32'h00000003, 5'd3);
    start_i = 1'b1;
    @(posedge clk);
    #1 drive(3'd5, 32'h00000064, 32'h00000007, 5'd9);
    wait_done(lat, bsy);
    check("b2b first latency", lat, 33);
    check("b2b first result", result_o, 32'h00000006);
    check("b2b first rd", {27'd0, rd_addr_o}, 32'd3);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(lat, bsy);
    check("b2b second latency", lat, 33);
    check("b2b second result", result_o, 32'h0000000E);
    check("b2b second rd", {27'd0, rd_addr_o}, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
